// File: rtl/vga_timing_gen.sv
// VGA timing generator. Walks a pixel grid of H_TOTAL x V_TOTAL positions. Origin (0,0) is the
// first visible pixel. Each line runs active, front porch, sync, back porch, and lines follow the
// same order within a frame. Every output is registered and decoded from the next-state counters,
// so each output describes the position held in the same cycle.

`timescale 1ns / 1ps

module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic       pclk,
  input  logic       rst_n,
  input  logic       enable,
  output logic       hsync,
  output logic       vsync,
  output logic       data_valid,
  output logic [9:0] h_data_cnt,
  output logic [9:0] v_data_cnt,
  output logic       line_start,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // Decode bounds are one bit wider so a sync pulse ending exactly at 1024 does not wrap.
  localparam logic [10:0] H_VIS_END  = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_VIS_END  = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0]  h_pos_q, h_pos_d;
  logic [9:0]  v_pos_q, v_pos_d;
  logic [10:0] h_ext, v_ext;
  logic        h_vis, v_vis, h_sync_win, v_sync_win;

  logic       hsync_q, vsync_q, data_valid_q, line_start_q, frame_start_q;
  logic [9:0] h_data_cnt_q, v_data_cnt_q;

  // Next position: h wraps at H_TOTAL-1, v steps only on the h wrap; both hold while disabled.
  always_comb begin
    h_pos_d = h_pos_q;
    v_pos_d = v_pos_q;
    if (enable) begin
      if (h_pos_q == H_LAST) begin
        h_pos_d = '0;
        if (v_pos_q == V_LAST) begin
          v_pos_d = '0;
        end else begin
          v_pos_d = v_pos_q + 10'd1;
        end
      end else begin
        h_pos_d = h_pos_q + 10'd1;
      end
    end
  end

  // Region decode of the next position, so the registered outputs line up with the counters.
  always_comb begin
    h_ext      = {1'b0, h_pos_d};
    v_ext      = {1'b0, v_pos_d};
    h_vis      = (h_ext < H_VIS_END);
    v_vis      = (v_ext < V_VIS_END);
    h_sync_win = (h_ext >= H_SYNC_BEG) && (h_ext < H_SYNC_END);
    v_sync_win = (v_ext >= V_SYNC_BEG) && (v_ext < V_SYNC_END);
  end

  // Position counters; reset parks them on the last position so the first enabled edge is (0,0).
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      h_pos_q <= H_LAST;
      v_pos_q <= V_LAST;
    end else begin
      h_pos_q <= h_pos_d;
      v_pos_q <= v_pos_d;
    end
  end

  // Registered outputs; pulses and data_valid drop while frozen, syncs and coordinates hold.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      data_valid_q  <= 1'b0;
      h_data_cnt_q  <= '0;
      v_data_cnt_q  <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (enable) begin
      hsync_q       <= h_sync_win ? SYNC_POL : ~SYNC_POL;
      vsync_q       <= v_sync_win ? SYNC_POL : ~SYNC_POL;
      data_valid_q  <= h_vis && v_vis;
      h_data_cnt_q  <= (h_vis && v_vis) ? h_pos_d : 10'd0;
      v_data_cnt_q  <= (h_vis && v_vis) ? v_pos_d : 10'd0;
      line_start_q  <= (h_pos_d == 10'd0) && v_vis;
      frame_start_q <= (h_pos_d == 10'd0) && (v_pos_d == 10'd0);
    end else begin
      data_valid_q  <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign data_valid  = data_valid_q;
  assign h_data_cnt  = h_data_cnt_q;
  assign v_data_cnt  = v_data_cnt_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-timing instance (active-low syncs) and a tiny-raster
// instance (active-high syncs) share stimulus. A position model derived from the count of enabled
// edges since reset predicts every output each cycle; literal checks pin the model.

`timescale 1ns / 1ps

module tb_vga_timing_gen;

  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic       dv;
    logic [9:0] hc;
    logic [9:0] vc;
    logic       ls;
    logic       fs;
  } out_t;

  logic       pclk   = 1'b0;
  logic       rst_n  = 1'b1;
  logic       enable = 1'b1;

  logic       a_hsync, a_vsync, a_dv, a_ls, a_fs;
  logic [9:0] a_hc, a_vc;
  logic       b_hsync, b_vsync, b_dv, b_ls, b_fs;
  logic [9:0] b_hc, b_vc;

  int checks = 0;
  int errors = 0;
  int k      = 0;   // enabled edges since reset
  bit last_en = 1'b0;
  int cyc    = 0;

  // Per-window statistics
  int st_dv_a, st_hs_a, st_vs_a, st_ls_a, st_fs_a, hmax_a, vmax_a, last_ls_cyc_a;
  int st_dv_b, st_hs_b, st_vs_b, st_ls_b, st_fs_b, vmax_b;
  int fs_cyc_b[2];

  vga_timing_gen u_dut_a (
    .pclk        (pclk),
    .rst_n       (rst_n),
    .enable      (enable),
    .hsync       (a_hsync),
    .vsync       (a_vsync),
    .data_valid  (a_dv),
    .h_data_cnt  (a_hc),
    .v_data_cnt  (a_vc),
    .line_start  (a_ls),
    .frame_start (a_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE (8),
    .H_FP     (2),
    .H_SYNC   (3),
    .H_BP     (3),
    .V_ACTIVE (6),
    .V_FP     (2),
    .V_SYNC   (2),
    .V_BP     (2),
    .SYNC_POL (1'b1)
  ) u_dut_b (
    .pclk        (pclk),
    .rst_n       (rst_n),
    .enable      (enable),
    .hsync       (b_hsync),
    .vsync       (b_vsync),
    .data_valid  (b_dv),
    .h_data_cnt  (b_hc),
    .v_data_cnt  (b_vc),
    .line_start  (b_ls),
    .frame_start (b_fs)
  );

  always #5 pclk = ~pclk;

  // Outputs for the raster position reached after kk enabled edges since reset.
  function automatic out_t model(int kk, bit en, int ha, int hf, int hs, int hb,
                                 int va, int vf, int vs, int vb, bit pol);
    int   ht, vt, idx, hp, vp;
    bit   vis;
    out_t o;
    ht      = ha + hf + hs + hb;
    vt      = va + vf + vs + vb;
    idx     = (kk + ht * vt - 1) % (ht * vt);
    hp      = idx % ht;
    vp      = idx / ht;
    vis     = (hp < ha) && (vp < va);
    o.hsync = (hp >= ha + hf && hp < ha + hf + hs) ? pol : !pol;
    o.vsync = (vp >= va + vf && vp < va + vf + vs) ? pol : !pol;
    o.dv    = en && vis;
    o.hc    = vis ? 10'(hp) : 10'd0;
    o.vc    = vis ? 10'(vp) : 10'd0;
    o.ls    = en && (hp == 0) && (vp < va);
    o.fs    = en && (hp == 0) && (vp == 0);
    return o;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic clear_stats();
    st_dv_a = 0; st_hs_a = 0; st_vs_a = 0; st_ls_a = 0; st_fs_a = 0; hmax_a = 0; vmax_a = 0;
    st_dv_b = 0; st_hs_b = 0; st_vs_b = 0; st_ls_b = 0; st_fs_b = 0; vmax_b = 0;
    fs_cyc_b[0] = -1; fs_cyc_b[1] = -1;
  endtask

  // One pclk: advance the model on the rising edge, compare both instances on the falling edge.
  task automatic tick();
    out_t ga, ea, gb, eb;
    @(posedge pclk);
    cyc++;
    if (!rst_n) begin
      k = 0; last_en = 1'b0;
    end else if (enable) begin
      k++; last_en = 1'b1;
    end else begin
      last_en = 1'b0;
    end
    @(negedge pclk);
    ga = {a_hsync, a_vsync, a_dv, a_hc, a_vc, a_ls, a_fs};
    gb = {b_hsync, b_vsync, b_dv, b_hc, b_vc, b_ls, b_fs};
    ea = model(k, last_en, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
    eb = model(k, last_en, 8, 2, 3, 3, 6, 2, 2, 2, 1'b1);
    checks++;
    if (ga !== ea) begin
      errors++;
      $display("FAIL model_a cyc=%0d got=%h expected=%h", cyc, ga, ea);
    end
    checks++;
    if (gb !== eb) begin
      errors++;
      $display("FAIL model_b cyc=%0d got=%h expected=%h", cyc, gb, eb);
    end
    if (a_dv) st_dv_a++;
    if (!a_hsync) st_hs_a++;
    if (!a_vsync) st_vs_a++;
    if (a_ls) begin st_ls_a++; last_ls_cyc_a = cyc; end
    if (a_fs) st_fs_a++;
    if (int'(a_hc) > hmax_a) hmax_a = int'(a_hc);
    if (int'(a_vc) > vmax_a) vmax_a = int'(a_vc);
    if (b_dv) st_dv_b++;
    if (b_hsync) st_hs_b++;
    if (b_vsync) st_vs_b++;
    if (b_ls) st_ls_b++;
    if (b_fs) begin
      if (st_fs_b < 2) fs_cyc_b[st_fs_b] = cyc;
      st_fs_b++;
    end
    if (int'(b_vc) > vmax_b) vmax_b = int'(b_vc);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_a_hsync"}, int'(a_hsync), 1);
    check({tag, "_a_vsync"}, int'(a_vsync), 1);
    check({tag, "_a_dv"}, int'(a_dv), 0);
    check({tag, "_a_hc"}, int'(a_hc), 0);
    check({tag, "_a_vc"}, int'(a_vc), 0);
    check({tag, "_a_ls"}, int'(a_ls), 0);
    check({tag, "_a_fs"}, int'(a_fs), 0);
    check({tag, "_b_hsync"}, int'(b_hsync), 0);
    check({tag, "_b_vsync"}, int'(b_vsync), 0);
  endtask

  task automatic check_origin(input string tag);
    check({tag, "_a_fs"}, int'(a_fs), 1);
    check({tag, "_a_ls"}, int'(a_ls), 1);
    check({tag, "_a_dv"}, int'(a_dv), 1);
    check({tag, "_a_hc"}, int'(a_hc), 0);
    check({tag, "_a_vc"}, int'(a_vc), 0);
    check({tag, "_b_fs"}, int'(b_fs), 1);
    check({tag, "_b_hsync"}, int'(b_hsync), 0);
  endtask

  initial begin
    int ls_line1;
    bit found;

    clear_stats();
    last_ls_cyc_a = -1;

    // Asynchronous reset before any clock edge
    #2 rst_n = 1'b0;
    #1 check_reset_values("rst_async0");
    tick();
    rst_n = 1'b1;

    // First enabled edge lands on the origin
    clear_stats();
    tick();
    check_origin("first_edge");

    // Line 0 of the default raster, with two full frames of the tiny raster on the way
    for (int i = 2; i <= 800; i++) begin
      tick();
      if (i == 384) begin
        check("b_fs_per_2frames", st_fs_b, 2);
        check("b_frame_period", fs_cyc_b[1] - fs_cyc_b[0], 192);
        check("b_dv_per_2frames", st_dv_b, 96);
        check("b_hsync_act_2frames", st_hs_b, 72);
        check("b_vsync_act_2frames", st_vs_b, 64);
        check("b_ls_per_2frames", st_ls_b, 12);
        check("b_vmax", vmax_b, 5);
      end
    end
    check("a_dv_line0", st_dv_a, 640);
    check("a_hsync_low_line0", st_hs_a, 96);
    check("a_vsync_low_line0", st_vs_a, 0);
    check("a_ls_line0", st_ls_a, 1);
    check("a_fs_line0", st_fs_a, 1);
    check("a_hmax_line0", hmax_a, 639);
    check("a_vmax_line0", vmax_a, 0);

    // Move to (100,1), then freeze for 50 cycles
    repeat (101) tick();
    ls_line1 = last_ls_cyc_a;
    check("a_hc_at_100", int'(a_hc), 100);
    check("a_vc_at_100", int'(a_vc), 1);
    enable = 1'b0;
    clear_stats();
    repeat (50) tick();
    check("freeze_hc_hold", int'(a_hc), 100);
    check("freeze_vc_hold", int'(a_vc), 1);
    check("freeze_dv_cycles", st_dv_a, 0);
    check("freeze_ls_cycles", st_ls_a + st_ls_b, 0);
    enable = 1'b1;
    tick();
    check("resume_hc", int'(a_hc), 101);
    check("resume_dv", int'(a_dv), 1);

    // Next line_start arrives 800 enabled + 50 frozen cycles after line 1's
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      tick();
      if (a_ls) found = 1'b1;
    end
    check("line2_found", int'(found), 1);
    check("line1_to_line2_cycles", last_ls_cyc_a - ls_line1, 850);
    check("line2_vc", int'(a_vc), 2);

    // Reset asserted mid-line at (300,2), between clock edges
    repeat (300) tick();
    check("a_hc_at_300", int'(a_hc), 300);
    #2 rst_n = 1'b0;
    #1 check_reset_values("rst_midframe");
    tick();
    rst_n = 1'b1;
    tick();
    check_origin("after_rst");

    // Free run to exercise wraps of the tiny raster under the per-cycle model
    repeat (400) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
